hdmi_fifo_fill_ctrl: RTL

HDMI_FIFO_FILL_CTRL -- requirements
Module: hdmi_fifo_fill_ctrl

---
 rtl/hdmi_fifo_fill_ctrl.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/hdmi_fifo_fill_ctrl.sv
// Pixel FIFO refill controller: turns half-FIFO fill pulses into BURST_LEN-word
// read requests that walk a frame buffer, with a one-deep fill queue and vsync abort.
module hdmi_fifo_fill_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int WORD_BYTES  = 4,
  parameter int BURST_LEN   = 16,
  parameter int HALF_WORDS  = 256,
  parameter int FRAME_WORDS = 307200
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fill_half_fifo_I,
  input  logic              hsync_I,
  input  logic              vsync_I,
  input  logic [ADDR_W-1:0] frame_base_I,
  input  logic              rd_ack_I,
  output logic              rd_req_O,
  output logic [ADDR_W-1:0] rd_addr_O,
  output logic              busy_O,
  output logic              overrun_O,
  output logic [15:0]       line_count_O
);

  localparam int NUM_BURSTS = HALF_WORDS / BURST_LEN;
  localparam int OFF_W      = $clog2(FRAME_WORDS + 1);
  localparam int BC_W       = $clog2(NUM_BURSTS + 1);

  typedef enum logic {IDLE, REQ} state_t;

  state_t              state_reg, state_next;
  logic [OFF_W-1:0]    offset_reg, offset_next;
  logic [BC_W-1:0]     burst_reg, burst_next;
  logic                pending_reg, pending_next;
  logic                abort_reg, abort_next;
  logic                rd_req_next;
  logic                busy_next;
  logic                overrun_next;
  logic [ADDR_W-1:0]   addr_next;
  logic [15:0]         line_next;
  logic [OFF_W:0]      off_sum;
  logic [OFF_W-1:0]    offset_adv;

  function automatic logic [ADDR_W-1:0] addr_of(input logic [OFF_W-1:0] off);
    return frame_base_I + ADDR_W'(off) * ADDR_W'(WORD_BYTES);
  endfunction

  // Word offset of the burst after the current one, wrapping at the frame end.
  always_comb begin
    off_sum    = {1'b0, offset_reg} + (OFF_W + 1)'(BURST_LEN);
    offset_adv = off_sum[OFF_W-1:0];
    if (off_sum >= (OFF_W + 1)'(FRAME_WORDS)) begin
      offset_adv = '0;
    end
  end

  always_comb begin
    state_next   = state_reg;
    offset_next  = offset_reg;
    burst_next   = burst_reg;
    pending_next = pending_reg;
    abort_next   = abort_reg;
    addr_next    = rd_addr_O;
    overrun_next = 1'b0;

    if (vsync_I) begin
      line_next = '0;
    end else if (hsync_I && (line_count_O != 16'hFFFF)) begin
      line_next = line_count_O + 16'd1;
    end else begin
      line_next = line_count_O;
    end

    case (state_reg)
      IDLE: begin
        if (vsync_I) begin
          offset_next = '0;
          abort_next  = 1'b0;
        end
        if (fill_half_fifo_I || pending_reg) begin
          // A fresh pulse arriving while a queued fill is being launched stays queued.
          state_next   = REQ;
          pending_next = pending_reg & fill_half_fifo_I;
          burst_next   = '0;
          addr_next    = addr_of(vsync_I ? '0 : offset_reg);
        end
      end
      REQ: begin
        if (fill_half_fifo_I) begin
          if (pending_reg) overrun_next = 1'b1;
          else             pending_next = 1'b1;
        end
        if (vsync_I) abort_next = 1'b1;
        if (rd_ack_I) begin
          if (abort_reg || vsync_I) begin
            state_next   = IDLE;
            offset_next  = '0;
            pending_next = 1'b0;
            burst_next   = '0;
            abort_next   = 1'b0;
          end else begin
            offset_next = offset_adv;
            addr_next   = addr_of(offset_adv);
            if (burst_reg == BC_W'(NUM_BURSTS - 1)) begin
              burst_next = '0;
              if (pending_reg) pending_next = 1'b0;
              else             state_next   = IDLE;
            end else begin
              burst_next = burst_reg + BC_W'(1);
            end
          end
        end
      end
      default: state_next = IDLE;
    endcase

    rd_req_next = (state_next == REQ);
    busy_next   = (state_next == REQ);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      offset_reg   <= '0;
      burst_reg    <= '0;
      pending_reg  <= 1'b0;
      abort_reg    <= 1'b0;
      rd_req_O     <= 1'b0;
      rd_addr_O    <= '0;
      busy_O       <= 1'b0;
      overrun_O    <= 1'b0;
      line_count_O <= '0;
    end else begin
      state_reg    <= state_next;
      offset_reg   <= offset_next;
      burst_reg    <= burst_next;
      pending_reg  <= pending_next;
      abort_reg    <= abort_next;
      rd_req_O     <= rd_req_next;
      rd_addr_O    <= addr_next;
      busy_O       <= busy_next;
      overrun_O    <= overrun_next;
      line_count_O <= line_next;
    end
  end

endmodule
